// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if : byte-stream input, program-memory write port, status
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif

interface program_loader_if #(
  parameter int IW = `INSTRUCTION_SIZE,
  parameter int AW = `ADDRESS_SIZE
);
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          prog_write;
  logic [AW-1:0] prog_address;
  logic [IW-1:0] prog_data;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, prog_write, prog_address, prog_data,
    input  core_reset, busy, done, error
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, prog_write, prog_address, prog_data,
    output core_reset, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader : receives a length-prefixed, XOR-checked byte frame and
// writes it word by word into program memory, then releases the core.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif

module program_loader (
  input  logic             clock,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int IW  = `INSTRUCTION_SIZE;
  localparam int AW  = `ADDRESS_SIZE;
  localparam int BPW = IW / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [16:0]    MAX_WORDS = 17'(1) << AW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]     state;
  logic [2:0]     next_state;

  logic [7:0]     len_hi;
  logic [15:0]    words_left;
  logic [7:0]     csum;
  logic [BCW-1:0] byte_cnt;
  logic [AW-1:0]  word_idx;
  logic [IW-1:0]  shift;

  logic           wr_strobe;
  logic [AW-1:0]  wr_address;
  logic [IW-1:0]  wr_data;

  logic           rx_ready;
  logic           busy;
  logic           done;
  logic           error;
  logic           core_reset;

  logic           accept;
  logic           start_taken;
  logic           word_complete;
  logic           last_word;
  logic [15:0]    frame_len;
  logic [IW-1:0]  word_next;

  assign accept        = bus.rx_valid && rx_ready;
  assign start_taken   = bus.start &&
                         (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign word_complete = (byte_cnt == LAST_BYTE);
  assign last_word     = (words_left == 16'd1);
  assign frame_len     = {len_hi, bus.rx_data};
  // Only the low IW bits survive, so the oldest byte falls off the top.
  assign word_next     = IW'({shift, bus.rx_data});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, frame_len} > MAX_WORDS) next_state = S_ERROR;
          else if (frame_len == 16'd0)       next_state = S_CHECK;
          else                               next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && word_complete && last_word) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (accept) next_state = (bus.rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_reset = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi     <= '0;
      words_left <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      shift      <= '0;
      wr_strobe  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_taken) begin
        len_hi     <= '0;
        words_left <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
        word_idx   <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_HI: len_hi     <= bus.rx_data;
          S_LEN_LO: words_left <= frame_len;
          S_DATA: begin
            csum  <= csum ^ bus.rx_data;
            shift <= word_next;
            if (word_complete) begin
              byte_cnt   <= '0;
              wr_strobe  <= 1'b1;
              wr_address <= word_idx;
              wr_data    <= word_next;
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.prog_write   = wr_strobe;
  assign bus.prog_address = wr_address;
  assign bus.prog_data    = wr_data;
  assign bus.core_reset   = core_reset;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader : directed vector table plus hand sequences for
// program_loader (IW=16, AW=4).
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif

module tb_program_loader;

  localparam int IW = `INSTRUCTION_SIZE;
  localparam int AW = `ADDRESS_SIZE;

  // Flag order: {rx_ready, busy, done, error, core_reset}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_BUSY = 5'b11000;
  localparam logic [4:0] F_DONE = 5'b00101;
  localparam logic [4:0] F_ERR  = 5'b00010;

  typedef struct {
    logic          start;
    logic          valid;
    logic [7:0]    data;
    logic          pw;
    logic [AW-1:0] addr;
    logic [IW-1:0] wdata;
    logic [4:0]    flags;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  program_loader_if #(.IW(IW), .AW(AW)) bus ();

  program_loader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic pw, input logic [AW-1:0] addr,
                           input logic [IW-1:0] wdata, input logic [4:0] flags);
    check({tag, " flags"}, 32'({bus.rx_ready, bus.busy, bus.done, bus.error, bus.core_reset}),
          32'(flags));
    check({tag, " prog_write"}, 32'(bus.prog_write), 32'(pw));
    if (pw) begin
      check({tag, " prog_address"}, 32'(bus.prog_address), 32'(addr));
      check({tag, " prog_data"}, 32'(bus.prog_data), 32'(wdata));
    end
  endtask

  task automatic apply(input logic s, input logic v, input logic [7:0] d);
    bus.start    = s;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d, input logic pw,
                     input logic [AW-1:0] a, input logic [IW-1:0] w, input logic [4:0] f);
    vec_t e;
    e.start = s; e.valid = v; e.data = d; e.pw = pw; e.addr = a; e.wdata = w; e.flags = f;
    vecs.push_back(e);
  endtask

  initial begin
    logic [7:0] sum;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Two-word frame; payload XOR is 12^34^AB^CD = 40.
    add(1, 0, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h02, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h12, 0, 0, 0, F_BUSY);
    add(0, 0, 8'hFF, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h34, 1, 0, 16'h1234, F_BUSY);
    add(1, 1, 8'hAB, 0, 0, 0, F_BUSY);
    add(0, 1, 8'hCD, 1, 1, 16'hABCD, F_BUSY);
    add(0, 0, 8'h40, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h40, 0, 0, 0, F_DONE);
    add(0, 1, 8'h55, 0, 0, 0, F_DONE);
    // Restart from DONE, same frame with a bad checksum.
    add(1, 0, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h02, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h12, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h34, 1, 0, 16'h1234, F_BUSY);
    add(0, 1, 8'hAB, 0, 0, 0, F_BUSY);
    add(0, 1, 8'hCD, 1, 1, 16'hABCD, F_BUSY);
    add(0, 1, 8'h67, 0, 0, 0, F_ERR);
    add(0, 1, 8'h00, 0, 0, 0, F_ERR);
    // Empty frame from ERROR.
    add(1, 0, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_DONE);
    // N = 17 exceeds the 16-word space.
    add(1, 0, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h11, 0, 0, 0, F_ERR);
    // N = 16, payload continues in the hand sequence below.
    add(1, 0, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h00, 0, 0, 0, F_BUSY);
    add(0, 1, 8'h10, 0, 0, 0, F_BUSY);

    #12;
    check_out("reset", 0, 0, 0, F_IDLE);
    check("reset prog_address", 32'(bus.prog_address), 32'd0);
    check("reset prog_data", 32'(bus.prog_data), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply(0, 1, 8'h00);
    check_out("idle no start", 0, 0, 0, F_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].start, vecs[i].valid, vecs[i].data);
      check_out($sformatf("v%0d", i), vecs[i].pw, vecs[i].addr, vecs[i].wdata, vecs[i].flags);
    end

    // Full address space: the last word lands at 15 and nothing wraps.
    sum = 8'h00;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'(k);
      lo = 8'hA0 + 8'(k);
      apply(0, 1, hi);
      check_out($sformatf("full%0d hi", k), 0, 0, 0, F_BUSY);
      apply(0, 1, lo);
      check_out($sformatf("full%0d lo", k), 1, AW'(k), {hi, lo}, F_BUSY);
      sum = sum ^ hi ^ lo;
    end
    apply(0, 1, sum);
    check_out("full csum", 0, 0, 0, F_DONE);

    // Reset mid-frame after one payload byte.
    apply(1, 0, 8'h00);
    apply(0, 1, 8'h00);
    apply(0, 1, 8'h01);
    apply(0, 1, 8'hBE);
    #2;
    reset = 1'b0;
    #1;
    check_out("midreset", 0, 0, 0, F_IDLE);
    check("midreset prog_address", 32'(bus.prog_address), 32'd0);
    check("midreset prog_data", 32'(bus.prog_data), 32'd0);
    @(posedge clock);
    #1;
    check_out("midreset held", 0, 0, 0, F_IDLE);
    reset = 1'b1;
    apply(0, 1, 8'hEF);
    check_out("post reset idle", 0, 0, 0, F_IDLE);
    apply(1, 0, 8'h00);
    apply(0, 1, 8'h00);
    apply(0, 1, 8'h01);
    apply(0, 1, 8'hBE);
    check_out("reload hi", 0, 0, 0, F_BUSY);
    apply(0, 1, 8'hEF);
    check_out("reload lo", 1, 0, 16'hBEEF, F_BUSY);
    apply(0, 1, 8'hBE ^ 8'hEF);
    check_out("reload csum", 0, 0, 0, F_DONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
